paralelo_serial: RTL

Byte-to-serial transmitter for the comma-framed serial link, running on the 32× bit clock. It converts 8-bit words into an MSB-first bit stream, one bit per `clk_32f` cycle, with an internal divide-by-8 byte frame. After reset, and whenever it is re-enabled, it emits a preamble of comma bytes (0xBC) so the far-end serial-to-parallel receiver can reach its active state before payload bytes are sent.

---
 rtl/paralelo_serial.sv | 87 ++++++++
 1 files changed

// File: rtl/paralelo_serial.sv
// Byte-to-serial MSB-first transmitter with comma preamble and divide-by-8 byte framing.
// Optional build macro PS_IDLE_COMMA_EN: idle bytes in ACTIVE are COMMA instead of 8'h00.
module paralelo_serial #(
    parameter int          SYNC_COMMAS = 4,
    parameter logic [7:0]  COMMA       = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       tx_en,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       load_ack,
    output logic       frame_start,
    output logic       active,
    output logic [2:0] bit_cnt
);

    typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COMMAS - 1);
`ifdef PS_IDLE_COMMA_EN
    localparam logic [7:0] IDLE_BYTE = COMMA;
`else
    localparam logic [7:0] IDLE_BYTE = 8'h00;
`endif

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic       load_ack_q, load_ack_d;
    logic       boundary;

    assign boundary = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_SYNC;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= 3'd7;
            sync_cnt_q <= 4'd0;
            load_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            load_ack_q <= load_ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = {shreg_q[6:0], 1'b0};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        sync_cnt_d = sync_cnt_q;
        load_ack_d = 1'b0;
        if (boundary) begin
            bit_cnt_d = 3'd0;
            // Disabling the link sends zeros and forces a fresh preamble later.
            if (!tx_en) begin
                shreg_d    = 8'h00;
                state_d    = ST_SYNC;
                sync_cnt_d = 4'd0;
            end else if (state_q == ST_SYNC) begin
                shreg_d    = COMMA;
                sync_cnt_d = sync_cnt_q + 4'd1;
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d = ST_ACTIVE;
                end
            end else if (valid_in) begin
                shreg_d    = data_in;
                load_ack_d = 1'b1;
            end else begin
                shreg_d = IDLE_BYTE;
            end
        end
    end

    assign data_out    = shreg_q[7];
    assign load_ack    = load_ack_q;
    assign frame_start = (bit_cnt_q == 3'd0);
    assign active      = (state_q == ST_ACTIVE);
    assign bit_cnt     = bit_cnt_q;

endmodule
